// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Package    : lc3b_types
// Description: Shared LC-3b types for the memory arbiter: the word type, the
//              byte-enable type, the arbiter state and port encodings, and a
//              helper that returns the effective downstream byte mask.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_t;

  // Reads always fetch the full word; writes keep the caller's byte enables.
  function automatic lc3b_mem_wmask eff_wmask(input logic is_write,
                                              input lc3b_mem_wmask mask);
    return is_write ? mask : 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_grant.sv
// ============================================================================
// Module     : arb_grant
// Description: Combinational grant select between port A and port B.
//              Macro MEM_ARB_ROUND_ROBIN_EN: when defined, a tie goes to the
//              port not granted last; otherwise B always wins a tie.
// Ports      : req_a, req_b  - port requests
//              last_grant    - port granted in the previous transaction
//              grant         - selected port (PORT_A when nothing requests)
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_grant
  import lc3b_types::*;
(
  input  logic      req_a,
  input  logic      req_b,
  input  arb_port_t last_grant,
  output arb_port_t grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = PORT_A;
    if (req_a && req_b) begin
      grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      grant = PORT_B;
    end
  end
`else
  // Fixed priority: port B carries the older instruction.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = PORT_A;
    if (req_b) begin
      grant = PORT_B;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module     : mem_arbiter
// Description: Two-port memory responder serialising the instruction port (A)
//              and data port (B) onto one downstream memory port. Level
//              requests, one-cycle response pulses, all outputs registered.
//              Macro MEM_ARB_ROUND_ROBIN_EN enables round-robin tie breaking
//              (default build: fixed B-over-A priority).
// Ports      : clk, reset_n                   - clock, async active-low reset
//              mem_read_x, mem_write_x        - port x request (level)
//              mem_address_x/wdata_x/wmask_x  - port x request fields
//              mem_resp_x, mem_rdata_x        - port x completion / read data
//              pmem_read/write/address/wdata/wmask - downstream request
//              pmem_resp, pmem_rdata          - downstream completion / data
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset_n,
  // port A
  input  logic          mem_read_a,
  input  logic          mem_write_a,
  input  lc3b_word      mem_address_a,
  input  lc3b_word      mem_wdata_a,
  input  logic [1:0]    mem_wmask_a,
  output logic          mem_resp_a,
  output lc3b_word      mem_rdata_a,
  // port B
  input  logic          mem_read_b,
  input  logic          mem_write_b,
  input  lc3b_word      mem_address_b,
  input  lc3b_word      mem_wdata_b,
  input  logic [1:0]    mem_wmask_b,
  output logic          mem_resp_b,
  output lc3b_word      mem_rdata_b,
  // downstream
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output logic [1:0]    pmem_wmask,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
);

  arb_state_t state, next_state;
  arb_port_t  grant;       // port owning the outstanding transaction
  arb_port_t  sel;         // combinational pick in IDLE
  arb_port_t  last_grant;

  logic       req_a, req_b, req_any;
  logic       sel_write;
  lc3b_word   sel_addr, sel_wdata;
  logic [1:0] sel_wmask;

  assign req_a   = mem_read_a | mem_write_a;
  assign req_b   = mem_read_b | mem_write_b;
  assign req_any = req_a | req_b;

  arb_grant u_grant (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .grant      (sel)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PORT_A;
    end else if (state == IDLE && req_any) begin
      last_grant <= sel;
    end
  end
`else
  assign last_grant = PORT_A;
`endif

  // Request fields of the selected port; read+write together counts as write.
  always_comb begin
    sel_write = mem_write_a;
    sel_addr  = mem_address_a;
    sel_wdata = mem_wdata_a;
    sel_wmask = mem_wmask_a;
    if (sel == PORT_B) begin
      sel_write = mem_write_b;
      sel_addr  = mem_address_b;
      sel_wdata = mem_wdata_b;
      sel_wmask = mem_wmask_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_any)   next_state = BUSY;
      BUSY:    if (pmem_resp) next_state = RESP;
      RESP:                   next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // The pmem_* registers double as the latched request: once in BUSY they
  // are never reloaded from the upstream ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= PORT_A;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_wmask   <= '0;
      mem_resp_a   <= 1'b0;
      mem_resp_b   <= 1'b0;
      mem_rdata_a  <= '0;
      mem_rdata_b  <= '0;
    end else begin
      mem_resp_a <= 1'b0;
      mem_resp_b <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            grant        <= sel;
            pmem_write   <= sel_write;
            pmem_read    <= ~sel_write;
            pmem_address <= sel_addr;
            pmem_wdata   <= sel_wdata;
            pmem_wmask   <= eff_wmask(sel_write, sel_wmask);
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (grant == PORT_A) begin
              mem_resp_a <= 1'b1;
              if (pmem_read) mem_rdata_a <= pmem_rdata;
            end else begin
              mem_resp_b <= 1'b1;
              if (pmem_read) mem_rdata_b <= pmem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module     : tb_mem_arbiter
// Description: Self-checking bench for mem_arbiter with a transaction-level
//              reference model (service order, expected downstream fields,
//              expected read data) and a scripted downstream responder.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read_a, mem_write_a, mem_read_b, mem_write_b;
  logic [15:0] mem_address_a, mem_wdata_a, mem_address_b, mem_wdata_b;
  logic [1:0]  mem_wmask_a, mem_wmask_b;
  logic        mem_resp_a, mem_resp_b;
  logic [15:0] mem_rdata_a, mem_rdata_b;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [1:0]  pmem_wmask;

  mem_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_read_a    (mem_read_a),
    .mem_write_a   (mem_write_a),
    .mem_address_a (mem_address_a),
    .mem_wdata_a   (mem_wdata_a),
    .mem_wmask_a   (mem_wmask_a),
    .mem_resp_a    (mem_resp_a),
    .mem_rdata_a   (mem_rdata_a),
    .mem_read_b    (mem_read_b),
    .mem_write_b   (mem_write_b),
    .mem_address_b (mem_address_b),
    .mem_wdata_b   (mem_wdata_b),
    .mem_wmask_b   (mem_wmask_b),
    .mem_resp_b    (mem_resp_b),
    .mem_rdata_b   (mem_rdata_b),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_wmask    (pmem_wmask),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Reference model state: port index 0 = A, 1 = B.
  int          last_port;
  logic [15:0] ref_rdata [2];

  // Per-round stimulus. op: 0 read, 1 write, 2 read+write (acts as write).
  bit          t_req   [2];
  int          t_op    [2];
  logic [15:0] t_addr  [2];
  logic [15:0] t_wdata [2];
  logic [1:0]  t_mask  [2];
  int          t_lat   [2];
  logic [15:0] t_rd    [2];
  bit          t_scr;

  task automatic drive_port(input int p, input bit rd, input bit wr,
                            input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
    if (p == 0) begin
      mem_read_a = rd; mem_write_a = wr; mem_address_a = a; mem_wdata_a = d; mem_wmask_a = m;
    end else begin
      mem_read_b = rd; mem_write_b = wr; mem_address_b = a; mem_wdata_b = d; mem_wmask_b = m;
    end
  endtask

  task automatic set_port(input int p, input bit req, input int op, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] m, input int lat,
                          input logic [15:0] rd);
    t_req[p] = req; t_op[p] = op; t_addr[p] = a; t_wdata[p] = d;
    t_mask[p] = m; t_lat[p] = lat; t_rd[p] = rd;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic run_round();
    int order[$];
    int first;
    for (int p = 0; p < 2; p++)
      if (t_req[p])
        drive_port(p, t_op[p] != 1, t_op[p] != 0, t_addr[p], t_wdata[p], t_mask[p]);
    if (t_req[0] && t_req[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      first = (last_port == 0) ? 1 : 0;
`else
      first = 1;
`endif
      order.push_back(first);
      order.push_back(1 - first);
    end else begin
      order.push_back(t_req[1] ? 1 : 0);
    end

    foreach (order[i]) begin
      int p;
      bit w;
      p = order[i];
      w = (t_op[p] != 0);
      if (i > 0) begin
        @(negedge clk);
        check("gap_resp", {mem_resp_a, mem_resp_b}, 0);
        check("gap_pmem", {pmem_read, pmem_write}, 0);
      end
      @(negedge clk);
      check("pmem_op", {pmem_read, pmem_write}, {!w, w});
      check("pmem_addr", pmem_address, t_addr[p]);
      check("pmem_wmask", pmem_wmask, w ? t_mask[p] : 2'b11);
      if (w) check("pmem_wdata", pmem_wdata, t_wdata[p]);
      last_port = p;
      for (int j = 1; j < t_lat[p]; j++) begin
        if (j == 1 && t_scr)
          drive_port(p, t_op[p] != 1, t_op[p] != 0, t_addr[p] ^ 16'h0200,
                     ~t_wdata[p], ~t_mask[p]);
        @(negedge clk);
        check("busy_addr", pmem_address, t_addr[p]);
        check("busy_op", {pmem_read, pmem_write}, {!w, w});
      end
      pmem_resp  = 1'b1;
      pmem_rdata = t_rd[p];
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = 16'($urandom);
      check("resp_pulse", {mem_resp_a, mem_resp_b}, (p == 0) ? 2'b10 : 2'b01);
      check("resp_pmem_drop", {pmem_read, pmem_write}, 0);
      if (!w) ref_rdata[p] = t_rd[p];
      check("rdata", (p == 0) ? mem_rdata_a : mem_rdata_b, ref_rdata[p]);
      drive_port(p, 1'b0, 1'b0, t_addr[p], t_wdata[p], t_mask[p]);
    end
    @(negedge clk);
    check("resp_one_cycle", {mem_resp_a, mem_resp_b}, 0);
    check("rdata_a_hold", mem_rdata_a, ref_rdata[0]);
    check("rdata_b_hold", mem_rdata_b, ref_rdata[1]);
  endtask

  initial begin
    reset_n    = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = 16'h0;
    drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    last_port    = 0;
    ref_rdata[0] = 16'h0;
    ref_rdata[1] = 16'h0;
    t_scr        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pmem_op", {pmem_read, pmem_write}, 0);
    check("rst_pmem_fields", {pmem_address, pmem_wdata}, 0);
    check("rst_pmem_wmask", pmem_wmask, 0);
    check("rst_resp", {mem_resp_a, mem_resp_b}, 0);
    check("rst_rdata", {mem_rdata_a, mem_rdata_b}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single read on A, 3-cycle memory.
    set_port(0, 1, 0, 16'h0040, 16'h0, 2'b00, 3, 16'h1234);
    set_port(1, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'h0);
    run_round();

    // Contention: A read vs B masked write.
    set_port(0, 1, 0, 16'h0010, 16'h0, 2'b00, 2, 16'h7777);
    set_port(1, 1, 1, 16'h0200, 16'hBEEF, 2'b01, 2, 16'hDEAD);
    run_round();

    // B address changes mid-BUSY; downstream must keep the latched one.
    set_port(0, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'h0);
    set_port(1, 1, 0, 16'h0100, 16'h0, 2'b00, 3, 16'h4321);
    t_scr = 1'b1;
    run_round();
    t_scr = 1'b0;

    // Zero-wait memory with back-to-back B reads.
    drive_port(1, 1'b1, 1'b0, 16'h0050, 16'h0, 2'b00);
    @(negedge clk);
    check("b2b_first", {pmem_read, pmem_address}, {1'b1, 16'h0050});
    pmem_resp = 1'b1; pmem_rdata = 16'h5A5A;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("b2b_resp1", {mem_resp_a, mem_resp_b}, 2'b01);
    ref_rdata[1] = 16'h5A5A;
    check("b2b_rdata1", mem_rdata_b, ref_rdata[1]);
    @(negedge clk);
    check("b2b_idle", {pmem_read, mem_resp_b}, 0);
    @(negedge clk);
    check("b2b_second", pmem_read, 1);
    pmem_resp = 1'b1; pmem_rdata = 16'hA5A5;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("b2b_resp2", {mem_resp_a, mem_resp_b}, 2'b01);
    ref_rdata[1] = 16'hA5A5;
    check("b2b_rdata2", mem_rdata_b, ref_rdata[1]);
    drive_port(1, 1'b0, 1'b0, 16'h0050, 16'h0, 2'b00);
    last_port = 1;
    @(negedge clk);
    check("b2b_end", {mem_resp_a, mem_resp_b}, 0);

    // Randomized rounds.
    for (int r = 0; r < 60; r++) begin
      for (int p = 0; p < 2; p++)
        set_port(p, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 16'($urandom) & 16'hFFFE, 16'($urandom), 2'($urandom),
                 $urandom_range(1, 4), 16'($urandom));
      if (!t_req[0] && !t_req[1]) t_req[$urandom_range(0, 1)] = 1'b1;
      t_scr = 1'($urandom_range(0, 1));
      run_round();
      if ($urandom_range(0, 3) == 0) begin
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        check("idle_resp_ignored", {mem_resp_a, mem_resp_b, pmem_read, pmem_write}, 0);
      end
    end

    // Asynchronous reset in the middle of a B read.
    drive_port(1, 1'b1, 1'b0, 16'h0123, 16'h0, 2'b00);
    @(negedge clk);
    check("areset_busy", pmem_read, 1);
    #2 reset_n = 1'b0;
    drive_port(1, 1'b0, 1'b0, 16'h0123, 16'h0, 2'b00);
    #1;
    check("areset_pmem_read", pmem_read, 0);
    check("areset_pmem_addr", pmem_address, 0);
    check("areset_rdata", {mem_rdata_a, mem_rdata_b}, 0);
    last_port    = 0;
    ref_rdata[0] = 16'h0;
    ref_rdata[1] = 16'h0;
    @(negedge clk);
    reset_n   = 1'b1;
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("late_resp_ignored", {mem_resp_a, mem_resp_b}, 0);
    @(negedge clk);
    check("late_resp_quiet", {mem_resp_a, mem_resp_b, pmem_read, pmem_write}, 0);

    // Contention straight after reset: B must win the tie in both builds.
    set_port(0, 1, 1, 16'h0AA0, 16'h1111, 2'b10, 1, 16'h0);
    set_port(1, 1, 0, 16'h0BB0, 16'h0, 2'b00, 2, 16'h2222);
    run_round();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
